// File: rtl/cmos_frame_gen_if.sv
// rtl/cmos_frame_gen_if.sv - camera pixel interface (vsync, href, RGB565 data, valid)
// Ports:
//   cam_vsync      : frame sync, active high
//   cam_href       : line valid, active high
//   cam_data       : RGB565 pixel, zero when cam_data_valid is low
//   cam_data_valid : pixel qualifier
// The master modport is the pixel source; the slave modport is the pixel consumer.
interface cmos_frame_gen_if;
    logic        cam_vsync;
    logic        cam_href;
    logic [15:0] cam_data;
    logic        cam_data_valid;

    modport master (
        output cam_vsync,
        output cam_href,
        output cam_data,
        output cam_data_valid
    );

    modport slave (
        input cam_vsync,
        input cam_href,
        input cam_data,
        input cam_data_valid
    );
endinterface

// File: rtl/cmos_frame_gen.sv
// rtl/cmos_frame_gen.sv - synthetic CMOS sensor raster and test-pattern source
// Ports:
//   cam_pclk   : sole clock, rising edge
//   rst        : synchronous active-high reset
//   gen_en     : run request; sampled in IDLE and on the last cycle of a frame
//   pat_mode   : 0 colour bars, 1 x+y ramp, 2 solid fill_color, 3 frame tag
//   fill_color : RGB565 colour for mode 2
//   cam        : pixel stream (vsync, href, data, valid), master side
//   frame_cnt  : completed-frame counter, wraps
//   frame_done : one-cycle pulse on the last cycle of each frame
//   busy       : high whenever a frame is in progress
module cmos_frame_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 160,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic                  cam_pclk,
    input  logic                  rst,
    input  logic                  gen_en,
    input  logic [1:0]            pat_mode,
    input  logic [15:0]           fill_color,
    cmos_frame_gen_if.master      cam,
    output logic [15:0]           frame_cnt,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int LINE_LEN = H_ACTIVE + H_BLANK;
    localparam int HC_W     = $clog2(LINE_LEN);
    localparam int LC_W     = 11;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int BC_W     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t            state, nxt_state;
    logic [HC_W-1:0]   hc, nxt_hc;
    logic [LC_W-1:0]   lc, nxt_lc;
    logic [BC_W-1:0]   bar_cnt, nxt_bar_cnt;
    logic [2:0]        bar_idx, nxt_bar_idx;
    logic [1:0]        pat_q;
    logic [15:0]       fill_q;

    logic              line_end;
    logic              pix_on;
    logic              frame_last;
    logic              new_frame;
    logic [10:0]       pix_x;
    logic [10:0]       pix_y;
    logic [15:0]       bar_color;
    logic [15:0]       pix_val;

    // Next-state and counter advance. Outputs are registered from these
    // next values so every output reflects the cycle the FSM is entering.
    always_comb begin
        nxt_state = state;
        nxt_hc    = hc;
        nxt_lc    = lc;
        line_end  = (hc == HC_W'(LINE_LEN - 1));
        if (state == S_IDLE) begin
            if (gen_en) begin
                nxt_state = S_VSYNC;
                nxt_hc    = '0;
                nxt_lc    = '0;
            end
        end else if (line_end) begin
            nxt_hc = '0;
            nxt_lc = lc + LC_W'(1);
            case (state)
                S_VSYNC: if (lc == LC_W'(VSYNC_LINES - 1)) begin
                    nxt_state = S_VBACK;
                    nxt_lc    = '0;
                end
                S_VBACK: if (lc == LC_W'(V_BACK - 1)) begin
                    nxt_state = S_ACTIVE;
                    nxt_lc    = '0;
                end
                S_ACTIVE: if (lc == LC_W'(V_ACTIVE - 1)) begin
                    nxt_state = S_VFRONT;
                    nxt_lc    = '0;
                end
                S_VFRONT: if (lc == LC_W'(V_FRONT - 1)) begin
                    nxt_state = gen_en ? S_VSYNC : S_IDLE;
                    nxt_lc    = '0;
                end
                default: begin
                    nxt_state = S_IDLE;
                    nxt_lc    = '0;
                end
            endcase
        end else begin
            nxt_hc = hc + HC_W'(1);
        end
    end

    always_comb begin
        pix_on     = (nxt_state == S_ACTIVE) && (nxt_hc < HC_W'(H_ACTIVE));
        frame_last = (nxt_state == S_VFRONT) && (nxt_hc == HC_W'(LINE_LEN - 1))
                     && (nxt_lc == LC_W'(V_FRONT - 1));
        // Entering VSYNC from IDLE or from the end of VFRONT starts a frame.
        new_frame  = (nxt_state == S_VSYNC) && (state != S_VSYNC);

        // Bar position tracks hc with a small counter instead of dividing x.
        nxt_bar_cnt = bar_cnt;
        nxt_bar_idx = bar_idx;
        if (nxt_hc == '0) begin
            nxt_bar_cnt = '0;
            nxt_bar_idx = '0;
        end else if (bar_cnt == BC_W'(BAR_W - 1)) begin
            nxt_bar_cnt = '0;
            nxt_bar_idx = bar_idx + 3'd1;
        end else begin
            nxt_bar_cnt = bar_cnt + BC_W'(1);
        end

        case (nxt_bar_idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase

        pix_x = 11'(nxt_hc);
        pix_y = nxt_lc;
        case (pat_q)
            2'd0:    pix_val = bar_color;
            2'd1:    pix_val = {5'b0, pix_x + pix_y};
            2'd2:    pix_val = fill_q;
            default: pix_val = {frame_cnt[7:0], pix_y[7:0]};
        endcase
    end

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            state              <= S_IDLE;
            hc                 <= '0;
            lc                 <= '0;
            bar_cnt            <= '0;
            bar_idx            <= '0;
            pat_q              <= '0;
            fill_q             <= '0;
            cam.cam_vsync      <= 1'b0;
            cam.cam_href       <= 1'b0;
            cam.cam_data_valid <= 1'b0;
            cam.cam_data       <= '0;
            frame_cnt          <= '0;
            frame_done         <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state   <= nxt_state;
            hc      <= nxt_hc;
            lc      <= nxt_lc;
            bar_cnt <= nxt_bar_cnt;
            bar_idx <= nxt_bar_idx;
            if (new_frame) begin
                pat_q  <= pat_mode;
                fill_q <= fill_color;
            end
            cam.cam_vsync      <= (nxt_state == S_VSYNC);
            cam.cam_href       <= pix_on;
            cam.cam_data_valid <= pix_on;
            cam.cam_data       <= pix_on ? pix_val : 16'h0000;
            frame_done         <= frame_last;
            if (frame_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            busy <= (nxt_state != S_IDLE);
        end
    end
endmodule
